gbsha_ttfir_sequencer: RTL
==========================

Name: gbsha_ttfir_sequencer

Overview:
- Host-side controller that drives the 8-bit pin bus of the 4-tap FIR tile `gbsha_ttfir_top`: `io_in = {x[5:0], reset, clk}`, `io_out = y[7:0]`.
- Generates the tile clock as a registered pin, with one FIR tick = two `clk` cycles, so the tile can be stalled by holding its clock low.
- Sequences the tile's post-reset load protocol: one mode word, then `N_TAPS` coefficients.
- Streams samples through a valid/ready port and reassembles the full 13-bit sum from the MSB and LSB output bytes.

Parameters:
- `N_TAPS`, 4, FIR taps; must match the tile.
- `BW_IN`, 6, sample/coefficient width.
- `BW_SUM`, 13, tile accumulator width.
- `BW_OUT`, 8, tile output byte width.

Ports:
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-high reset.
- `cfg_start` input 1: start configuration; honoured only in IDLE.
- `cfg_stop` input 1: return to IDLE; honoured only in RUN_WAIT.
- `cfg_lsb_mode` input 1: latched at start; 1 = full-precision (MSB+LSB) mode.
- `coef_we` input 1: coefficient write; honoured only in IDLE.
- `coef_waddr` input 2: tap index; 0 = tap applied to the newest sample.
- `coef_wdata` input BW_IN: signed coefficient.
- `s_valid` input 1: sample valid.
- `s_data` input BW_IN: signed sample.
- `s_ready` output 1: sample accept.
- `y_valid` output 1: one-cycle result strobe; no backpressure.
- `y_data` output BW_SUM: signed result.
- `loaded` output 1: tile configured and streaming.
- `busy` output 1: state != IDLE.
- `fir_io_in` output 8: `{x[5:0], fir_reset, fir_clk}` to the tile.
- `fir_io_out` input 8: tile `y[7:0]`.

Behaviour:
- **Async reset values:**
  - state = IDLE; `fir_clk` = 0; `fir_reset` = 1 (tile held in reset); x = 0.
  - `s_ready`, `y_valid`, `loaded`, `busy` = 0; `y_data` = 0.
  - Coefficient regs = 0; latched mode = 0.
- **All `fir_io_in` fields are registered.** x/`fir_reset` change only when entering a `*_LO` state. `fir_clk` = 1 exactly in `*_HI` states, so the tile samples data that has been stable for one full cycle.
- **Capture point:** `fir_io_out` is captured on the `clk` edge that ends an `*_HI` state, i.e. one cycle after the tile's rising edge.
- **FSM:**
  - IDLE: `fir_reset` = 1. On `cfg_start`, latch `cfg_lsb_mode` and go to RST_LO.
  - RST_LO/RST_HI: `fir_reset` = 1.
  - MODE_LO/MODE_HI: `fir_reset` = 0, x = `{0, lsb_mode}`.
  - LOAD_LO/LOAD_HI ×N_TAPS: x = coef[N_TAPS-1] first, down to coef[0] last.
  - RUN_WAIT: `loaded` = 1.
- **Configuration timing:** 2·(2+N_TAPS) = 12 cycles from the `cfg_start` cycle until the first RUN_WAIT cycle.
- **RUN_WAIT:** `s_ready` = !`cfg_stop`.
  - On `s_valid & s_ready`: x <= `s_data`, go to RLO → RHI.
  - Then, if lsb_mode: SLO → SHI (x = 0) → RUN_WAIT; otherwise RUN_WAIT directly.
  - With no handshake, `fir_clk` stays 0 (tile stalled); the state holds indefinitely.
  - On `cfg_stop`: go to IDLE, `fir_reset` <= 1, `loaded` <= 0. `cfg_stop` wins over a simultaneous `s_valid`.
- **Throughput:** one sample per 3 cycles in MSB mode, per 5 cycles in LSB mode (with `s_valid` held).
- **Results:**
  - The byte captured after RHI is msb; the byte captured after SHI is lsb.
  - MSB mode: `y_data` = `{msb, 5'b0}`; `y_valid` = 1 in the cycle after RHI.
  - LSB mode: `y_data` = `{msb, lsb[4:0]}`, which is exactly the 13-bit sum; `y_valid` = 1 in the cycle after SHI.
  - `y_data` holds until the next result.
- **Ignored requests:** coefficient writes and `cfg_start` outside IDLE are ignored; the coefficient regs retain their values.
- **Reset mid-operation:** immediately returns all values to the reset state. Any in-flight result is dropped (no `y_valid`).

Test Plan:
- Write coefs [1,2,3,4] to taps 0..3, lsb_mode = 1, start → `fir_io_in` LO-phase x sequence = 1 (mode), 4, 3, 2, 1; `loaded` rises 12 cycles after start. Then stream samples 1,0,0,0 → `y_data` = 1,2,3,4, each `y_valid` one cycle after SHI.
- All coefs 31, lsb_mode = 0, samples 31 ×4 back-to-back → `y_valid` every 3 cycles, `y_data` = 960, 1920, 2880, 3840.
- Coefs [1,0,0,0], lsb_mode = 1, sample −1 → `y_data` = 13'h1FFF (−1). Coef −32 with sample −32 → `y_data` = 1024.
- Stall: deassert `s_valid` for 10 cycles in RUN_WAIT → `fir_clk` stays 0, no `y_valid`. On resume, results are identical to the unstalled run.
- `coef_we` and `cfg_start` during RUN_WAIT → ignored. `cfg_stop` with `s_valid` = 1 → `s_ready` = 0, IDLE next cycle, `fir_reset` = 1, `loaded` = 0.
- Assert `reset` during LOAD_HI and again during RHI → outputs take reset values the same cycle, no `y_valid`; a subsequent start reloads cleanly and test 1 passes again.

Source files
------------

// File: rtl/gbsha_ttfir_sequencer.sv
// gbsha_ttfir_sequencer
// Host-side controller for the 4-tap FIR tile gbsha_ttfir_top. It drives the
// tile's 8-bit pin bus, generates the tile clock as a registered pin, runs
// the post-reset load protocol and streams samples through a valid/ready port.
// Each tile result is rebuilt from its MSB byte and, in full-precision mode,
// its LSB byte.
//
// Ports
//   clk, reset           system clock, asynchronous active-high reset
//   cfg_start            start configuration (IDLE only)
//   cfg_stop             return to IDLE (RUN_WAIT only)
//   cfg_lsb_mode         latched at start: 1 = full-precision (MSB+LSB) mode
//   coef_we/waddr/wdata  coefficient write port (IDLE only); tap 0 = newest
//   s_valid/s_data       sample input; s_ready is the accept
//   y_valid/y_data       one-cycle result strobe and signed result (held)
//   loaded               tile configured and streaming
//   busy                 controller not idle
//   fir_io_in            {x, fir_reset, fir_clk} to the tile
//   fir_io_out           tile output byte
module gbsha_ttfir_sequencer #(
    parameter int unsigned N_TAPS = 4,
    parameter int unsigned BW_IN  = 6,
    parameter int unsigned BW_SUM = 13,
    parameter int unsigned BW_OUT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_start,
    input  logic                  cfg_stop,
    input  logic                  cfg_lsb_mode,
    input  logic                  coef_we,
    input  logic [1:0]            coef_waddr,
    input  logic [BW_IN-1:0]      coef_wdata,
    input  logic                  s_valid,
    input  logic [BW_IN-1:0]      s_data,
    output logic                  s_ready,
    output logic                  y_valid,
    output logic [BW_SUM-1:0]     y_data,
    output logic                  loaded,
    output logic                  busy,
    output logic [BW_IN+1:0]      fir_io_in,
    input  logic [BW_OUT-1:0]     fir_io_out
);

    localparam int unsigned TAP_W = 2;
    localparam int unsigned LSB_W = BW_SUM - BW_OUT;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RST_LO,
        ST_RST_HI,
        ST_MODE_LO,
        ST_MODE_HI,
        ST_LOAD_LO,
        ST_LOAD_HI,
        ST_RUN_WAIT,
        ST_RLO,
        ST_RHI,
        ST_SLO,
        ST_SHI
    } state_t;

    state_t              state_q, state_d;
    logic [TAP_W-1:0]    tap_q, tap_d;
    logic [BW_IN-1:0]    x_q, x_d;
    logic                fir_rst_q, fir_rst_d;
    logic                fir_clk_q, fir_clk_d;
    logic                mode_q, mode_d;
    logic [BW_OUT-1:0]   msb_q, msb_d;
    logic                y_valid_q, y_valid_d;
    logic [BW_SUM-1:0]   y_data_q, y_data_d;
    logic                loaded_q, loaded_d;
    logic                busy_q, busy_d;
    logic [BW_IN-1:0]    coef_q [N_TAPS];
    logic [BW_IN-1:0]    coef_d [N_TAPS];
    logic                s_ready_c;

    // Sample accept must drop in the same cycle cfg_stop is raised.
    assign s_ready_c = (state_q == ST_RUN_WAIT) && !cfg_stop;

    // Next-state and registered-output logic; pin data changes only on entry
    // to a LO state so the tile sees it stable for a full cycle before its edge.
    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        x_d       = x_q;
        fir_rst_d = fir_rst_q;
        mode_d    = mode_q;
        msb_d     = msb_q;
        y_valid_d = 1'b0;
        y_data_d  = y_data_q;
        coef_d    = coef_q;

        if (state_q == ST_IDLE && coef_we) begin
            coef_d[coef_waddr] = coef_wdata;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    mode_d    = cfg_lsb_mode;
                    state_d   = ST_RST_LO;
                    fir_rst_d = 1'b1;
                    x_d       = '0;
                end
            end
            ST_RST_LO:  state_d = ST_RST_HI;
            ST_RST_HI: begin
                state_d   = ST_MODE_LO;
                fir_rst_d = 1'b0;
                x_d       = BW_IN'(mode_q);
            end
            ST_MODE_LO: state_d = ST_MODE_HI;
            ST_MODE_HI: begin
                // Highest tap goes first; the tile shifts coefficients in.
                state_d = ST_LOAD_LO;
                tap_d   = TAP_W'(N_TAPS - 1);
                x_d     = coef_q[N_TAPS-1];
            end
            ST_LOAD_LO: state_d = ST_LOAD_HI;
            ST_LOAD_HI: begin
                if (tap_q == '0) begin
                    state_d = ST_RUN_WAIT;
                end else begin
                    state_d = ST_LOAD_LO;
                    tap_d   = tap_q - TAP_W'(1);
                    x_d     = coef_q[tap_q - TAP_W'(1)];
                end
            end
            ST_RUN_WAIT: begin
                // Stop takes priority; with no handshake the tile clock stays low.
                if (cfg_stop) begin
                    state_d   = ST_IDLE;
                    fir_rst_d = 1'b1;
                end else if (s_valid) begin
                    state_d = ST_RLO;
                    x_d     = s_data;
                end
            end
            ST_RLO:     state_d = ST_RHI;
            ST_RHI: begin
                msb_d = fir_io_out;
                if (mode_q) begin
                    state_d = ST_SLO;
                    x_d     = '0;
                end else begin
                    state_d   = ST_RUN_WAIT;
                    y_valid_d = 1'b1;
                    y_data_d  = {fir_io_out, LSB_W'(0)};
                end
            end
            ST_SLO:     state_d = ST_SHI;
            ST_SHI: begin
                state_d   = ST_RUN_WAIT;
                y_valid_d = 1'b1;
                y_data_d  = {msb_q, fir_io_out[LSB_W-1:0]};
            end
            default:    state_d = ST_IDLE;
        endcase

        fir_clk_d = state_d inside {ST_RST_HI, ST_MODE_HI, ST_LOAD_HI, ST_RHI, ST_SHI};
        loaded_d  = state_d inside {ST_RUN_WAIT, ST_RLO, ST_RHI, ST_SLO, ST_SHI};
        busy_d    = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            tap_q     <= '0;
            x_q       <= '0;
            fir_rst_q <= 1'b1;
            fir_clk_q <= 1'b0;
            mode_q    <= 1'b0;
            msb_q     <= '0;
            y_valid_q <= 1'b0;
            y_data_q  <= '0;
            loaded_q  <= 1'b0;
            busy_q    <= 1'b0;
            coef_q    <= '{default: '0};
        end else begin
            state_q   <= state_d;
            tap_q     <= tap_d;
            x_q       <= x_d;
            fir_rst_q <= fir_rst_d;
            fir_clk_q <= fir_clk_d;
            mode_q    <= mode_d;
            msb_q     <= msb_d;
            y_valid_q <= y_valid_d;
            y_data_q  <= y_data_d;
            loaded_q  <= loaded_d;
            busy_q    <= busy_d;
            coef_q    <= coef_d;
        end
    end

    assign s_ready   = s_ready_c;
    assign y_valid   = y_valid_q;
    assign y_data    = y_data_q;
    assign loaded    = loaded_q;
    assign busy      = busy_q;
    assign fir_io_in = {x_q, fir_rst_q, fir_clk_q};

endmodule
